// File: rtl/mesh_ep_pkg.sv
// Shared types and packet helpers for the mesh traffic endpoint.
package mesh_ep_pkg;

  typedef enum logic [1:0] {
    GEN_OFF      = 2'd0,
    GEN_PERIODIC = 2'd1,
    GEN_SATURATE = 2'd2
  } gen_mode_t;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_SEND = 2'd1,
    G_WAIT = 2'd2
  } gen_state_t;

  // Packet layout is {x, y, payload}; widths are passed in so one helper serves any parameterisation.
  function automatic logic [63:0] pack_pkt(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] pay, input int unsigned addr_w,
                                           input int unsigned pay_w);
    logic [63:0] amask;
    logic [63:0] pmask;
    amask = (64'd1 << addr_w) - 64'd1;
    pmask = (64'd1 << pay_w) - 64'd1;
    return ((64'(x) & amask) << (addr_w + pay_w)) | ((64'(y) & amask) << pay_w) | (64'(pay) & pmask);
  endfunction

  // Destination field {x, y} of a packet.
  function automatic logic [63:0] pkt_dest(input logic [63:0] pkt, input int unsigned pay_w);
    return pkt >> pay_w;
  endfunction

  // Payload field of a packet.
  function automatic logic [63:0] pkt_payload(input logic [63:0] pkt, input int unsigned pay_w);
    return pkt & ((64'd1 << pay_w) - 64'd1);
  endfunction

endpackage

// File: rtl/mesh_traffic_endpoint_if.sv
// Valid/ready packet link between the endpoint and the mesh router.
interface mesh_traffic_endpoint_if #(
  parameter int unsigned WIDTH = 15
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ep_sink.sv
// Packet sink: registered ready, saturating accept counter, payload capture, misroute flag.
module ep_sink
  import mesh_ep_pkg::*;
#(
  parameter int unsigned WIDTH  = 15,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0,
  localparam int unsigned PAY_W = WIDTH - 2 * ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sink_en,
  mesh_traffic_endpoint_if.slave        rx,
  output logic [15:0]                   rx_count,
  output logic [PAY_W-1:0]              rx_last,
  output logic                          misroute_err
);

  localparam int unsigned DEST_W = 2 * ADDR_W;
  localparam logic [DEST_W-1:0] MY_DEST = {ADDR_W'(MY_X), ADDR_W'(MY_Y)};

  logic              accept;
  logic [DEST_W-1:0] dest;
  logic [PAY_W-1:0]  payload;

  assign accept  = rx.valid && rx.ready;
  assign dest    = DEST_W'(pkt_dest(64'(rx.data), PAY_W));
  assign payload = PAY_W'(pkt_payload(64'(rx.data), PAY_W));

  // Sink state: ready follows sink_en one cycle late; counters and capture update on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.ready     <= 1'b0;
      rx_count     <= '0;
      rx_last      <= '0;
      misroute_err <= 1'b0;
    end else begin
      rx.ready <= sink_en;
      if (accept) begin
        if (rx_count != '1) rx_count <= rx_count + 16'd1;
        rx_last <= payload;
        if (dest != MY_DEST) misroute_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_traffic_endpoint.sv
// Mesh local-port traffic endpoint: sequence-numbered packet source plus checking sink.
module mesh_traffic_endpoint
  import mesh_ep_pkg::*;
#(
  parameter int unsigned WIDTH  = 15,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0,
  parameter int unsigned PERIOD = 4,
  localparam int unsigned PAY_W = WIDTH - 2 * ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            gen_mode,
  input  logic [2*ADDR_W-1:0]   gen_dest,
  input  logic [15:0]           gen_limit,
  mesh_traffic_endpoint_if.master tx,
  output logic [15:0]           tx_count,
  output logic                  gen_done,
  input  logic                  sink_en,
  mesh_traffic_endpoint_if.slave rx,
  output logic [15:0]           rx_count,
  output logic [PAY_W-1:0]      rx_last,
  output logic                  misroute_err
);

  localparam int unsigned GAP_W   = $clog2(PERIOD + 1);
  localparam bit          HAS_GAP = (PERIOD > 1);

  gen_state_t       state, state_n;
  gen_mode_t        mode_q, mode_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic             valid_n;
  logic [WIDTH-1:0] data_n;
  logic [15:0]      count_n;
  logic [15:0]      count_inc;
  logic             mode_on;
  logic             done_after;

  function automatic logic [WIDTH-1:0] make_pkt(input logic [2*ADDR_W-1:0] dest,
                                                input logic [PAY_W-1:0] seq);
    return WIDTH'(pack_pkt(32'(dest[2*ADDR_W-1:ADDR_W]), 32'(dest[ADDR_W-1:0]),
                           32'(seq), ADDR_W, PAY_W));
  endfunction

  assign mode_on    = (gen_mode == GEN_PERIODIC) || (gen_mode == GEN_SATURATE);
  assign gen_done   = (gen_limit != '0) && (tx_count >= gen_limit);
  assign count_inc  = (tx_count == '1) ? tx_count : tx_count + 16'd1;
  assign done_after = (gen_limit != '0) && (count_inc >= gen_limit);

  // Source state, registered valid/data and accepted-packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= G_IDLE;
      mode_q   <= GEN_OFF;
      gap      <= '0;
      tx.valid <= 1'b0;
      tx.data  <= '0;
      tx_count <= '0;
    end else begin
      state    <= state_n;
      mode_q   <= mode_n;
      gap      <= gap_n;
      tx.valid <= valid_n;
      tx.data  <= data_n;
      tx_count <= count_n;
    end
  end

  // Source next-state: mode/dest are resampled whenever a fresh packet is launched, and a
  // pending packet is never withdrawn, so OFF or a lowered limit only take effect after it.
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    gap_n   = gap;
    valid_n = tx.valid;
    data_n  = tx.data;
    count_n = tx_count;
    case (state)
      G_IDLE: begin
        if (mode_on && !gen_done) begin
          state_n = G_SEND;
          valid_n = 1'b1;
          data_n  = make_pkt(gen_dest, tx_count[PAY_W-1:0]);
          mode_n  = gen_mode_t'(gen_mode);
        end
      end
      G_SEND: begin
        if (tx.ready) begin
          count_n = count_inc;
          if (done_after || !mode_on) begin
            state_n = G_IDLE;
            valid_n = 1'b0;
          end else if (mode_q == GEN_PERIODIC && HAS_GAP) begin
            state_n = G_WAIT;
            valid_n = 1'b0;
            gap_n   = GAP_W'(1);
          end else begin
            valid_n = 1'b1;
            data_n  = make_pkt(gen_dest, count_inc[PAY_W-1:0]);
            mode_n  = gen_mode_t'(gen_mode);
          end
        end
      end
      G_WAIT: begin
        if (!mode_on || gen_done) begin
          state_n = G_IDLE;
          gap_n   = '0;
        end else if (gap >= GAP_W'(PERIOD - 1)) begin
          state_n = G_SEND;
          gap_n   = '0;
          valid_n = 1'b1;
          data_n  = make_pkt(gen_dest, tx_count[PAY_W-1:0]);
          mode_n  = gen_mode_t'(gen_mode);
        end else begin
          gap_n = gap + GAP_W'(1);
        end
      end
      default: begin
        state_n = G_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  ep_sink #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .MY_X  (MY_X),
    .MY_Y  (MY_Y)
  ) u_sink (
    .clk         (clk),
    .rst_n       (rst_n),
    .sink_en     (sink_en),
    .rx          (rx),
    .rx_count    (rx_count),
    .rx_last     (rx_last),
    .misroute_err(misroute_err)
  );

endmodule

// File: tb/tb_mesh_traffic_endpoint.sv
// Self-checking bench for mesh_traffic_endpoint (default parameters, MY_X=MY_Y=0, PERIOD=4).
module tb_mesh_traffic_endpoint;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  gen_mode = 2'd0;
  logic [3:0]  gen_dest = 4'd0;
  logic [15:0] gen_limit = 16'd0;
  logic [15:0] tx_count;
  logic        gen_done;
  logic        sink_en = 1'b0;
  logic [15:0] rx_count;
  logic [10:0] rx_last;
  logic        misroute_err;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  mesh_traffic_endpoint_if #(.WIDTH(15)) tx_if ();
  mesh_traffic_endpoint_if #(.WIDTH(15)) rx_if ();

  mesh_traffic_endpoint #(
    .WIDTH (15),
    .ADDR_W(2),
    .MY_X  (0),
    .MY_Y  (0),
    .PERIOD(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gen_mode    (gen_mode),
    .gen_dest    (gen_dest),
    .gen_limit   (gen_limit),
    .tx          (tx_if),
    .tx_count    (tx_count),
    .gen_done    (gen_done),
    .sink_en     (sink_en),
    .rx          (rx_if),
    .rx_count    (rx_count),
    .rx_last     (rx_last),
    .misroute_err(misroute_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        v;
    logic [14:0] d;
    logic        rdy;
    logic [15:0] cnt;
    logic [10:0] last;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tx_valid"}, 32'(tx_if.valid), 32'd0);
    check({tag, " tx_data"}, 32'(tx_if.data), 32'd0);
    check({tag, " tx_count"}, 32'(tx_count), 32'd0);
    check({tag, " gen_done"}, 32'(gen_done), 32'd0);
    check({tag, " rx_ready"}, 32'(rx_if.ready), 32'd0);
    check({tag, " rx_count"}, 32'(rx_count), 32'd0);
    check({tag, " rx_last"}, 32'(rx_last), 32'd0);
    check({tag, " misroute"}, 32'(misroute_err), 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tx_check(input string tag, input logic v, input logic [14:0] d, input logic [15:0] c);
    check({tag, " valid"}, 32'(tx_if.valid), 32'(v));
    if (v) check({tag, " data"}, 32'(tx_if.data), 32'(d));
    check({tag, " count"}, 32'(tx_count), 32'(c));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    tx_if.ready = 1'b0;
    rx_if.valid = 1'b0;
    rx_if.data  = '0;

    // Sink vectors: accept uses rx_ready from the previous step (sink_en delayed one cycle).
    vecs[0] = '{1'b1, 1'b0, 15'h0000, 1'b1, 16'd0, 11'h000, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 15'h0123, 1'b1, 16'd1, 11'h123, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 15'h2456, 1'b1, 16'd2, 11'h456, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 15'h0077, 1'b0, 16'd3, 11'h077, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 15'h0055, 1'b0, 16'd3, 11'h077, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 15'h0011, 1'b1, 16'd3, 11'h077, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 15'h0022, 1'b1, 16'd3, 11'h077, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 15'h07FF, 1'b1, 16'd4, 11'h7FF, 1'b1};

    // Reset state
    #13;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sink table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sink_en     = vecs[i].en;
      rx_if.valid = vecs[i].v;
      rx_if.data  = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("sink%0d rx_ready", i), 32'(rx_if.ready), 32'(vecs[i].rdy));
      check($sformatf("sink%0d rx_count", i), 32'(rx_count), 32'(vecs[i].cnt));
      check($sformatf("sink%0d rx_last", i), 32'(rx_last), 32'(vecs[i].last));
      check($sformatf("sink%0d misroute", i), 32'(misroute_err), 32'(vecs[i].err));
      check($sformatf("sink%0d tx idle", i), 32'(tx_if.valid), 32'd0);
    end
    @(negedge clk);
    rx_if.valid = 1'b0;

    // Saturating burst with limit 5, dest 0101 -> packets 0x2800..0x2804
    gen_mode  = 2'd2;
    gen_limit = 16'd5;
    gen_dest  = 4'b0101;
    tx_if.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tx_check($sformatf("burst%0d", i), 1'b1, 15'h2800 + 15'(i), 16'(i));
      check($sformatf("burst%0d gen_done", i), 32'(gen_done), 32'd0);
    end
    @(posedge clk);
    #1;
    tx_check("burst end", 1'b0, 15'h0, 16'd5);
    check("burst end gen_done", 32'(gen_done), 32'd1);
    @(posedge clk);
    #1;
    tx_check("burst idle", 1'b0, 15'h0, 16'd5);

    // Unlimited saturate resumes from count 5, then async reset mid-burst
    @(negedge clk);
    gen_limit = 16'd0;
    @(posedge clk);
    #1;
    tx_check("resume", 1'b1, 15'h2805, 16'd5);
    repeat (2) @(posedge clk);
    #1;
    tx_check("resume+2", 1'b1, 15'h2807, 16'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tx_check("restart", 1'b1, 15'h2800, 16'd0);

    // Stall: tx_ready low for 3 cycles freezes data and count
    @(posedge clk);
    #1;
    tx_check("pre-stall a", 1'b1, 15'h2801, 16'd1);
    @(posedge clk);
    #1;
    tx_check("pre-stall b", 1'b1, 15'h2802, 16'd2);
    @(negedge clk);
    tx_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tx_check($sformatf("stall%0d", i), 1'b1, 15'h2802, 16'd2);
    end
    @(negedge clk);
    tx_if.ready = 1'b1;
    @(posedge clk);
    #1;
    tx_check("unstall", 1'b1, 15'h2803, 16'd3);

    // Mode to OFF while a packet is pending: held until accepted, then idle
    @(negedge clk);
    tx_if.ready = 1'b0;
    gen_mode = 2'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tx_check($sformatf("off-pending%0d", i), 1'b1, 15'h2803, 16'd3);
    end
    @(negedge clk);
    tx_if.ready = 1'b1;
    @(posedge clk);
    #1;
    tx_check("off-accepted", 1'b0, 15'h0, 16'd4);
    @(posedge clk);
    #1;
    tx_check("off-idle", 1'b0, 15'h0, 16'd4);

    // Periodic mode: one accept every 4 cycles, payload wraps after 2048 packets
    reset_pulse();
    gen_mode  = 2'd1;
    gen_dest  = 4'b1110;
    gen_limit = 16'd0;
    tx_if.ready = 1'b1;
    found = 1'b0;
    for (int e = 1; e <= 9000; e++) begin
      @(posedge clk);
      #1;
      if (e <= 12) begin
        check($sformatf("periodic e%0d valid", e), 32'(tx_if.valid), 32'((e % 4) == 1));
        check($sformatf("periodic e%0d count", e), 32'(tx_count), 32'((e + 2) / 4));
      end
      if (tx_if.valid && tx_count == 16'd2047)
        check("periodic seq 2047", 32'(tx_if.data), 32'h77FF);
      if (tx_if.valid && tx_count == 16'd2048) begin
        check("periodic wrap data", 32'(tx_if.data), 32'h7000);
        check("periodic wrap edge", 32'(e), 32'd8193);
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL periodic wrap: packet 2048 not seen within 9000 cycles");
    end

    // Limit lowered below tx_count: gen_done at once, pending packet still completes
    gen_limit = 16'd1;
    #1;
    check("limit lowered gen_done", 32'(gen_done), 32'd1);
    check("limit lowered valid held", 32'(tx_if.valid), 32'd1);
    @(posedge clk);
    #1;
    tx_check("limit lowered accept", 1'b0, 15'h0, 16'd2049);
    check("limit lowered gen_done after", 32'(gen_done), 32'd1);
    @(posedge clk);
    #1;
    tx_check("limit lowered idle", 1'b0, 15'h0, 16'd2049);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
